// File: rtl/bus_arbiter_if.sv
// Signal bundle for the two-master shared-bus arbiter: requester ports (m0 = CPU, m1 = DMA)
// plus the decoder-facing shared bus. 'slave' is the arbiter side, 'master' is the environment.
interface bus_arbiter_if #(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
);
   logic          m0_req;
   logic          m0_write;
   logic [AW-1:0] m0_addr;
   logic [DW-1:0] m0_wdata;
   logic          m0_gnt;
   logic          m0_ack;
   logic [DW-1:0] m0_rdata;

   logic          m1_req;
   logic          m1_write;
   logic [AW-1:0] m1_addr;
   logic [DW-1:0] m1_wdata;
   logic          m1_gnt;
   logic          m1_ack;
   logic [DW-1:0] m1_rdata;

   logic [AW-1:0] b_addr;
   logic [DW-1:0] b_wdata;
   logic          b_write;
   logic [DW-1:0] b_rdata;

   modport slave (
      input  m0_req, m0_write, m0_addr, m0_wdata,
      output m0_gnt, m0_ack, m0_rdata,
      input  m1_req, m1_write, m1_addr, m1_wdata,
      output m1_gnt, m1_ack, m1_rdata,
      output b_addr, b_wdata, b_write,
      input  b_rdata
   );

   modport master (
      output m0_req, m0_write, m0_addr, m0_wdata,
      input  m0_gnt, m0_ack, m0_rdata,
      output m1_req, m1_write, m1_addr, m1_wdata,
      input  m1_gnt, m1_ack, m1_rdata,
      input  b_addr, b_wdata, b_write,
      output b_rdata
   );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master shared-bus arbiter with IDLE/ACCESS/WAIT/DONE transfer sequencing.
// Define BUS_ARBITER_RR_EN for round-robin arbitration; default is fixed priority (m0 wins).
module bus_arbiter #(
   parameter int unsigned AW  = 32,
   parameter int unsigned DW  = 32,
   parameter int unsigned LAT = 1
) (
   input logic          clk,
   input logic          rst_n,
   bus_arbiter_if.slave bus
);
   localparam int unsigned CW = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          sel_q, sel_d;
   logic          write_q, write_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic          b_write_q, b_write_d;
   logic [1:0]    gnt_q, gnt_d;
   logic [1:0]    ack_q, ack_d;
   logic [DW-1:0] rdata0_q, rdata0_d;
   logic [DW-1:0] rdata1_q, rdata1_d;
   logic          any_req_c;
   logic          win_c;
`ifdef BUS_ARBITER_RR_EN
   logic          last_q, last_d;
`endif

   assign any_req_c = bus.m0_req | bus.m1_req;

   // Winner index among the current requesters (only meaningful when any_req_c)
`ifdef BUS_ARBITER_RR_EN
   assign win_c = (bus.m0_req & bus.m1_req) ? ~last_q : bus.m1_req;
`else
   assign win_c = ~bus.m0_req;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         sel_q     <= 1'b0;
         write_q   <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         b_write_q <= 1'b0;
         gnt_q     <= 2'b00;
         ack_q     <= 2'b00;
         rdata0_q  <= '0;
         rdata1_q  <= '0;
`ifdef BUS_ARBITER_RR_EN
         last_q    <= 1'b1;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sel_q     <= sel_d;
         write_q   <= write_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         b_write_q <= b_write_d;
         gnt_q     <= gnt_d;
         ack_q     <= ack_d;
         rdata0_q  <= rdata0_d;
         rdata1_q  <= rdata1_d;
`ifdef BUS_ARBITER_RR_EN
         last_q    <= last_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_req_c) state_d = ACCESS;
         ACCESS:  state_d = (LAT == 0) ? DONE : WAIT;
         WAIT:    if (cnt_q <= CW'(1)) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Registered outputs and datapath; values are those seen during the next state
   always_comb begin
      cnt_d     = cnt_q;
      sel_d     = sel_q;
      write_d   = write_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      b_write_d = 1'b0;
      gnt_d     = gnt_q;
      ack_d     = 2'b00;
      rdata0_d  = rdata0_q;
      rdata1_d  = rdata1_q;
`ifdef BUS_ARBITER_RR_EN
      last_d    = last_q;
`endif
      case (state_q)
         IDLE: begin
            if (any_req_c) begin
               sel_d     = win_c;
               write_d   = win_c ? bus.m1_write : bus.m0_write;
               addr_d    = win_c ? bus.m1_addr  : bus.m0_addr;
               wdata_d   = win_c ? bus.m1_wdata : bus.m0_wdata;
               b_write_d = write_d;
               gnt_d     = win_c ? 2'b10 : 2'b01;
            end
         end
         ACCESS: cnt_d = CW'(LAT);
         WAIT:   cnt_d = cnt_q - CW'(1);
         DONE: begin
            gnt_d = 2'b00;
`ifdef BUS_ARBITER_RR_EN
            last_d = sel_q;
`endif
         end
         default: ;
      endcase

      // Read data is valid on the bus in the cycle before DONE; capture it with the ack
      if ((state_d == DONE) && (state_q != DONE)) begin
         ack_d[sel_q] = 1'b1;
         if (!write_q) begin
            if (sel_q) rdata1_d = bus.b_rdata;
            else       rdata0_d = bus.b_rdata;
         end
      end
   end

   assign bus.b_addr   = addr_q;
   assign bus.b_wdata  = wdata_q;
   assign bus.b_write  = b_write_q;
   assign bus.m0_gnt   = gnt_q[0];
   assign bus.m1_gnt   = gnt_q[1];
   assign bus.m0_ack   = ack_q[0];
   assign bus.m1_ack   = ack_q[1];
   assign bus.m0_rdata = rdata0_q;
   assign bus.m1_rdata = rdata1_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: a transaction-level model predicts service order and data,
// a negedge monitor checks every ack. Extra LAT=0 / LAT=3 instances check ack latency.
module tb_bus_arbiter;
   localparam int unsigned AW  = 32;
   localparam int unsigned DW  = 32;
   localparam int unsigned LAT = 1;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   bus_arbiter_if #(.AW(AW), .DW(DW)) bi  ();
   bus_arbiter_if #(.AW(AW), .DW(DW)) bi0 ();
   bus_arbiter_if #(.AW(AW), .DW(DW)) bi3 ();

   bus_arbiter #(.AW(AW), .DW(DW), .LAT(LAT)) dut      (.clk(clk), .rst_n(rst_n), .bus(bi));
   bus_arbiter #(.AW(AW), .DW(DW), .LAT(0))   dut_lat0 (.clk(clk), .rst_n(rst_n), .bus(bi0));
   bus_arbiter #(.AW(AW), .DW(DW), .LAT(3))   dut_lat3 (.clk(clk), .rst_n(rst_n), .bus(bi3));

   // Simple decoder: 16-word memory indexed by addr[5:2]; combinational read
   logic [DW-1:0] mem [16];
   bit mem_init = 1'b0;

   function automatic logic [DW-1:0] init_word(input int i);
      return (i == 4) ? 32'hCAFE_0001 : (32'h1000_0000 + DW'(i));
   endfunction

   always @(posedge clk) begin
      if (!mem_init) begin
         for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
         mem_init <= 1'b1;
      end else if (bi.b_write) begin
         mem[bi.b_addr[5:2]] <= bi.b_wdata;
      end
   end

   assign bi.b_rdata  = mem[bi.b_addr[5:2]];
   assign bi0.b_rdata = 32'hA000_0000 | bi0.b_addr;
   assign bi3.b_rdata = 32'hA000_0000 | bi3.b_addr;

   // Reference model state
   typedef struct {
      int            m;
      bit            wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wd;
      logic [DW-1:0] rd;
   } exp_t;

   exp_t          exp_q[$];
   logic [DW-1:0] ref_mem [16];
   logic [DW-1:0] ref_rd  [2];
   int            last_srv;
   int            tests = 0;
   int            fails = 0;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endfunction

   function automatic int winner();
`ifdef BUS_ARBITER_RR_EN
      return (last_srv == 0) ? 1 : 0;
`else
      return 0;
`endif
   endfunction

   function automatic void serve(input int m, input bit wr, input logic [AW-1:0] a,
                                 input logic [DW-1:0] d);
      exp_t e;
      int   idx;
      idx    = int'(a[5:2]);
      e.m    = m;
      e.wr   = wr;
      e.addr = a;
      e.wd   = d;
      if (wr) ref_mem[idx] = d;
      else    ref_rd[m]    = ref_mem[idx];
      e.rd = ref_rd[m];
      exp_q.push_back(e);
      last_srv = m;
   endfunction

   task automatic set_m(input int m, input bit req, input bit wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
      if (m == 0) begin
         bi.m0_req = req; bi.m0_write = wr; bi.m0_addr = a; bi.m0_wdata = d;
      end else begin
         bi.m1_req = req; bi.m1_write = wr; bi.m1_addr = a; bi.m1_wdata = d;
      end
   endtask

   // Monitor: pops one expectation per ack and checks master, latency, bus and read data
   int   cyc = 0;
   int   g_start [2];
   bit   g_prev  [2];
   bit   g_now   [2];
   bit   a_now   [2];
   logic [DW-1:0] rd_now [2];
   int   bw_cnt = 0;
   exp_t e_mon;

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         g_prev[0] = 1'b0;
         g_prev[1] = 1'b0;
         bw_cnt    = 0;
      end else begin
         g_now[0] = bi.m0_gnt;  g_now[1] = bi.m1_gnt;
         a_now[0] = bi.m0_ack;  a_now[1] = bi.m1_ack;
         rd_now[0] = bi.m0_rdata; rd_now[1] = bi.m1_rdata;
         if (g_now[0] || g_now[1]) chk("gnt_exclusive", 64'(g_now[0] & g_now[1]), 64'd0);
         if (bi.b_write) bw_cnt++;
         for (int m = 0; m < 2; m++) begin
            if (g_now[m] && !g_prev[m]) g_start[m] = cyc;
            g_prev[m] = g_now[m];
            if (a_now[m]) begin
               chk("ack_expected", 64'(exp_q.size() == 0), 64'd0);
               if (exp_q.size() != 0) begin
                  e_mon = exp_q.pop_front();
                  chk("ack_master", 64'(m), 64'(e_mon.m));
                  chk("ack_latency", 64'(cyc - g_start[m]), 64'(LAT + 1));
                  chk("b_addr_held", 64'(bi.b_addr), 64'(e_mon.addr));
                  chk("b_write_cycles", 64'(bw_cnt), 64'(e_mon.wr));
                  if (e_mon.wr) chk("b_wdata_held", 64'(bi.b_wdata), 64'(e_mon.wd));
                  chk("rdata", 64'(rd_now[m]), 64'(e_mon.rd));
               end
               bw_cnt = 0;
            end
         end
      end
   end

   // One round: the given masters request together; each drops its req on its own ack
   task automatic round(input bit r0, input bit r1);
      bit            rq [2];
      bit            w  [2];
      logic [AW-1:0] a  [2];
      logic [DW-1:0] d  [2];
      int            f;
      int            n;
      rq[0] = r0; rq[1] = r1;
      for (int m = 0; m < 2; m++) begin
         w[m] = 1'($urandom_range(0, 1));
         a[m] = AW'($urandom_range(0, 15) * 4);
         d[m] = DW'($urandom);
      end
      @(negedge clk);
      for (int m = 0; m < 2; m++) if (rq[m]) set_m(m, 1'b1, w[m], a[m], d[m]);
      if (r0 && r1) begin
         f = winner();
         serve(f, w[f], a[f], d[f]);
         serve(1 - f, w[1-f], a[1-f], d[1-f]);
      end else begin
         f = r1 ? 1 : 0;
         serve(f, w[f], a[f], d[f]);
      end
      n = 0;
      while ((rq[0] || rq[1]) && n < 40) begin
         @(negedge clk);
         n++;
         if (rq[0] && bi.m0_ack) begin rq[0] = 1'b0; bi.m0_req = 1'b0; end
         if (rq[1] && bi.m1_ack) begin rq[1] = 1'b0; bi.m1_req = 1'b0; end
      end
      chk("round_complete", 64'(rq[0] || rq[1]), 64'd0);
   endtask

   // Both masters hold req high (reads) across n consecutive transfers
   task automatic contend(input int n);
      int w;
      int acks;
      int c;
      @(negedge clk);
      set_m(0, 1'b1, 1'b0, 32'h10, '0);
      set_m(1, 1'b1, 1'b0, 32'h14, '0);
      for (int i = 0; i < n; i++) begin
         w = winner();
         serve(w, 1'b0, (w == 0) ? 32'h10 : 32'h14, '0);
      end
      acks = 0;
      c    = 0;
      while (acks < n && c < 100) begin
         @(negedge clk);
         c++;
         if (bi.m0_ack || bi.m1_ack) acks++;
      end
      bi.m0_req = 1'b0;
      bi.m1_req = 1'b0;
      chk("contend_acks", 64'(acks), 64'(n));
   endtask

   // Latency check on the LAT=0 (which=0) or LAT=3 (which=3) instance
   task automatic lat_check(input int which);
      int exp_lat;
      int n;
      bit got;
      logic [DW-1:0] rd;
      exp_lat = (which == 0) ? 2 : 5;
      @(negedge clk);
      if (which == 0) begin bi0.m0_req = 1'b1; bi0.m0_addr = 32'h20; end
      else            begin bi3.m0_req = 1'b1; bi3.m0_addr = 32'h20; end
      n   = 0;
      got = 1'b0;
      rd  = '0;
      while (!got && n < 30) begin
         @(negedge clk);
         n++;
         got = (which == 0) ? bi0.m0_ack : bi3.m0_ack;
         rd  = (which == 0) ? bi0.m0_rdata : bi3.m0_rdata;
      end
      bi0.m0_req = 1'b0;
      bi3.m0_req = 1'b0;
      chk((which == 0) ? "lat0_ack_cycle" : "lat3_ack_cycle", 64'(n), 64'(exp_lat));
      chk((which == 0) ? "lat0_rdata" : "lat3_rdata", 64'(rd), 64'h0000_0000_A000_0020);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      set_m(0, 1'b0, 1'b0, '0, '0);
      set_m(1, 1'b0, 1'b0, '0, '0);
      bi0.m0_req = 1'b0; bi0.m0_write = 1'b0; bi0.m0_addr = '0; bi0.m0_wdata = '0;
      bi0.m1_req = 1'b0; bi0.m1_write = 1'b0; bi0.m1_addr = '0; bi0.m1_wdata = '0;
      bi3.m0_req = 1'b0; bi3.m0_write = 1'b0; bi3.m0_addr = '0; bi3.m0_wdata = '0;
      bi3.m1_req = 1'b0; bi3.m1_write = 1'b0; bi3.m1_addr = '0; bi3.m1_wdata = '0;
      for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
      ref_rd[0] = '0;
      ref_rd[1] = '0;
      last_srv  = 1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      chk("reset_gnt", 64'({bi.m1_gnt, bi.m0_gnt}), 64'd0);
      chk("reset_ack", 64'({bi.m1_ack, bi.m0_ack}), 64'd0);
      chk("reset_b_write", 64'(bi.b_write), 64'd0);
      chk("reset_b_addr", 64'(bi.b_addr), 64'd0);
      chk("reset_rdata", 64'(bi.m0_rdata | bi.m1_rdata), 64'd0);

      lat_check(0);
      lat_check(3);

      // Single read from m0
      @(negedge clk);
      set_m(0, 1'b1, 1'b0, 32'h10, '0);
      serve(0, 1'b0, 32'h10, '0);
      repeat (3) @(negedge clk);
      chk("single_read_ack", 64'(bi.m0_ack), 64'd1);
      bi.m0_req = 1'b0;
      chk("single_read_data", 64'(bi.m0_rdata), 64'h0000_0000_CAFE_0001);

      // Single write from m1
      @(negedge clk);
      set_m(1, 1'b1, 1'b1, 32'h800, 32'h00FF);
      serve(1, 1'b1, 32'h800, 32'h00FF);
      @(negedge clk);
      chk("single_write_strobe", 64'(bi.b_write), 64'd1);
      chk("single_write_addr", 64'(bi.b_addr), 64'h800);
      repeat (2) @(negedge clk);
      chk("single_write_ack", 64'(bi.m1_ack), 64'd1);
      bi.m1_req = 1'b0;
      chk("single_write_rdata", 64'(bi.m1_rdata), 64'd0);

      contend(4);

      // m0 drops req while its transfer is in ACCESS
      @(negedge clk);
      set_m(0, 1'b1, 1'b0, 32'h24, '0);
      serve(0, 1'b0, 32'h24, '0);
      @(negedge clk);
      chk("drop_gnt_access", 64'(bi.m0_gnt), 64'd1);
      bi.m0_req = 1'b0;
      repeat (6) @(negedge clk);

      for (int r = 0; r < 40; r++) begin
         bit r0, r1;
         r0 = 1'($urandom_range(0, 1));
         r1 = 1'($urandom_range(0, 1));
         if (!r0 && !r1) r0 = 1'b1;
         round(r0, r1);
      end

      // Reset while m1 read sits in WAIT
      @(negedge clk);
      set_m(1, 1'b1, 1'b0, 32'h18, '0);
      @(negedge clk);
      chk("rst_pre_gnt", 64'(bi.m1_gnt), 64'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_gnt", 64'({bi.m1_gnt, bi.m0_gnt}), 64'd0);
      chk("rst_mid_ack", 64'({bi.m1_ack, bi.m0_ack}), 64'd0);
      chk("rst_mid_b_write", 64'(bi.b_write), 64'd0);
      chk("rst_mid_b_addr", 64'(bi.b_addr), 64'd0);
      chk("rst_mid_rdata", 64'(bi.m1_rdata), 64'd0);
      bi.m1_req = 1'b0;
      ref_rd[0] = '0;
      ref_rd[1] = '0;
      last_srv  = 1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      round(1'b1, 1'b1);
      round(1'b1, 1'b0);

      repeat (5) @(negedge clk);
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, address width.
REQ-002 SHALL have parameter DW, default 32, data width.
REQ-003 SHALL have parameter LAT, default 1, range 0..15, cycles from bus-drive cycle to read data valid.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports mN_req  input  1  master N (N=0 CPU, N=1 DMA) requests a transfer.
REQ-007 SHALL have ports mN_write  input  1  1 = write, 0 = read.
REQ-008 SHALL have ports mN_addr  input  AW  transfer address.
REQ-009 SHALL have ports mN_wdata  input  DW  write data.
REQ-010 SHALL have ports mN_gnt  output  1  master N owns shared bus.
REQ-011 SHALL have ports mN_ack  output  1  one-cycle completion pulse.
REQ-012 SHALL have ports mN_rdata  output  DW  registered read data.
REQ-013 SHALL have port b_addr  output  AW  shared bus address to decoder.
REQ-014 SHALL have port b_wdata  output  DW  shared bus write data.
REQ-015 SHALL have port b_write  output  1  shared bus write strobe.
REQ-016 SHALL have port b_rdata  input  DW  muxed read data from decoder.

Function
REQ-017 SHALL implement FSM states IDLE, ACCESS, WAIT, DONE.
REQ-018 SHALL sample mN_req only in IDLE; with any req high, select a winner, latch its addr/wdata/write, go to ACCESS next cycle.
REQ-019 SHALL in ACCESS drive latched addr/wdata onto b_addr/b_wdata and assert b_write (if write) for exactly one cycle, load counter with LAT.
REQ-020 SHALL go ACCESS->DONE when LAT=0, else ACCESS->WAIT; WAIT decrements counter, exits to DONE when it reaches 1.
REQ-021 SHALL hold b_addr/b_wdata stable from ACCESS through DONE; b_write SHALL be 0 in every state but ACCESS.
REQ-022 SHALL in DONE capture b_rdata into winner's mN_rdata (reads only; writes leave it unchanged), pulse winner's mN_ack one cycle, return to IDLE.
REQ-023 SHALL assert winner's mN_gnt from ACCESS through DONE inclusive; never both gnt high.
REQ-024 SHALL complete a started transfer even if mN_req drops mid-transfer; req held through DONE is not re-served until the following IDLE cycle.
REQ-025 SHALL give transfer latency IDLE-sample to ack of LAT+2 cycles; back-to-back throughput one transfer per LAT+3 cycles.
REQ-026 SHALL hold mN_rdata until the next read completion for that master.

Reset
REQ-027 SHALL on rst_n low immediately force state IDLE, b_write/mN_gnt/mN_ack 0, b_addr/b_wdata/mN_rdata 0, counter 0, last-served pointer 1.
REQ-028 SHALL abort an in-flight transfer on reset with no ack; first cycle after release is IDLE.

Configuration
REQ-029 SHALL with macro BUS_ARBITER_RR_EN defined arbitrate round-robin: on simultaneous req, master not last served wins; pointer updates at DONE.
REQ-030 SHALL without BUS_ARBITER_RR_EN use fixed priority: m0 always wins simultaneous requests.
REQ-031 SHALL in both modes grant a sole requester without delay.

Verification
REQ-032 SHALL verify single read: LAT=1, m0 read addr 0x10, b_rdata=0xCAFE0001 -> b_write 0, m0_ack at cycle 3, m0_rdata=0xCAFE0001.
REQ-033 SHALL verify single write: m1 write addr 0x800, wdata 0x00FF -> b_write high exactly one cycle with b_addr 0x800, m1_ack once, m1_rdata unchanged.
REQ-034 SHALL verify contention: m0,m1 both held high for 4 transfers -> RR_EN order m0,m1,m0,m1; without macro m0 x4, m1 starved.
REQ-035 SHALL verify LAT=0 and LAT=3: ack at cycles 2 and 5 after request sampled.
REQ-036 SHALL verify reset mid-WAIT: rst_n low during m1 read -> b_write/gnt/ack 0 immediately, no m1_ack, IDLE after release.
REQ-037 SHALL verify req drop: m0 req deasserted in ACCESS -> transfer completes, m0_ack pulses once.
